// File: rtl/score_bcd_scheduler_pkg.sv
// score_bcd_scheduler_pkg: shared FSM encodings and display constants.
package score_bcd_scheduler_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONVERT = 2'd1;
  localparam logic [1:0] ACK = 2'd2;
  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam logic [2:0] DIG_ONES = 3'b001;
  localparam logic [2:0] DIG_TENS = 3'b010;
  localparam logic [2:0] DIG_HUNS = 3'b100;
endpackage

// File: rtl/score_bcd_scheduler_bcd_converter.sv
// BCDConverter: combinational 8-bit binary to 3-digit BCD {hundreds, tens, ones}.
module BCDConverter (
  input  logic [7:0]  bin,
  output logic [11:0] bcd
);
  always_comb bcd = {4'(bin / 8'd100), 4'((bin / 8'd10) % 8'd10), 4'(bin % 8'd10)};
endmodule

// File: rtl/score_bcd_scheduler_digit_scanner.sv
// digit_scanner: rotates a one-hot digit enable every SCAN_DIV clocks with leading-zero blanking.
module digit_scanner
  import score_bcd_scheduler_pkg::*;
#(
  parameter logic [15:0] SCAN_DIV = 16'd50000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] bcd,
  output logic [2:0]  digit_en,
  output logic [3:0]  digit_val
);
  logic [15:0] cnt;
  logic        wrap;
  logic [2:0]  en_nxt;
  logic [3:0]  hun, ten, one, nib;
  // digit_val is computed for the enable it will be paired with, keeping both registers aligned
  always_comb begin
    wrap = cnt == SCAN_DIV - 16'd1;
    en_nxt = wrap ? {digit_en[1:0], digit_en[2]} : digit_en;
    hun = bcd[11:8];
    ten = bcd[7:4];
    one = bcd[3:0];
    nib = en_nxt == DIG_HUNS ? ((BLANK_LZ && hun == 4'd0) ? BLANK_CODE : hun) :
          en_nxt == DIG_TENS ? ((BLANK_LZ && hun == 4'd0 && ten == 4'd0) ? BLANK_CODE : ten) : one;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 16'd0;
      digit_en <= DIG_ONES;
      digit_val <= 4'd0;
    end else begin
      cnt <= wrap ? 16'd0 : cnt + 16'd1;
      digit_en <= en_nxt;
      digit_val <= nib;
    end
  end
endmodule

// File: rtl/score_bcd_scheduler.sv
// score_bcd_scheduler: round-robin sharing of one BCD converter between live and high score, plus digit scan.
module score_bcd_scheduler
  import score_bcd_scheduler_pkg::*;
#(
  parameter logic [15:0] SCAN_DIV = 16'd50000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [7:0]  val0,
  input  logic [7:0]  val1,
  output logic [1:0]  ack,
  output logic [11:0] bcd0,
  output logic [11:0] bcd1,
  output logic        busy,
  input  logic        disp_sel,
  output logic [2:0]  digit_en,
  output logic [3:0]  digit_val
);
  logic [1:0]  state;
  logic [7:0]  operand;
  logic        owner, last_served, win;
  logic [11:0] conv, scan_bcd;
  BCDConverter u_conv (.bin(operand), .bcd(conv));
  // on a tie the requester not served last wins
  always_comb begin
    win = req[1] & (~req[0] | ~last_served);
    scan_bcd = disp_sel ? bcd1 : bcd0;
  end
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ack <= 2'b00;
      bcd0 <= 12'h000;
      bcd1 <= 12'h000;
      operand <= 8'd0;
      owner <= 1'b0;
      last_served <= 1'b1;
    end else begin
      ack <= 2'b00;
      if (state == IDLE && req != 2'b00) begin
        state <= CONVERT;
        owner <= win;
        operand <= win ? val1 : val0;
      end else if (state == CONVERT) begin
        if (owner) bcd1 <= conv;
        else bcd0 <= conv;
        ack <= owner ? 2'b10 : 2'b01;
        last_served <= owner;
        state <= ACK;
      end else if (state != IDLE) begin
        state <= IDLE;
      end
    end
  end
  digit_scanner #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(BLANK_LZ)) u_scan (
    .clk(clk), .reset(reset), .bcd(scan_bcd), .digit_en(digit_en), .digit_val(digit_val)
  );
endmodule
